rollover_period_meter: RTL
==========================

# rollover_period_meter

Receive-side companion to the mod-k rollover counter: observes a rollover pulse train and recovers the modulus k by measuring the cycle distance between consecutive rollover events. Reports each measured period, flags lock when two consecutive periods agree, and flags overflow when no event arrives within the measurable range. Sits downstream of any rollover source, for example in divider self-checks or in tick-rate detection, and is driven in the same clock domain.

## Interface
- N, default 8: counter and result width; measurable periods are 1 .. 2^N-1.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_roll_over  input  1  rollover event; every cycle in which it is high counts as one event.
- o_k  output  N  last measured period in cycles; holds its value between measurements.
- o_valid  output  1  one-cycle pulse when o_k is updated.
- o_locked  output  1  high while the last two consecutive measured periods are equal.
- o_overflow  output  1  sticky; set when a period exceeds 2^N-1; cleared by the next o_valid or by reset.

## Operation
- Internal state: FSM {IDLE, MEASURE}, cnt[N-1:0], have_prev (1 bit).
- Reset (i_reset=1 at a rising edge): state=IDLE, cnt=0, have_prev=0, o_k=0, o_valid=0, o_locked=0, o_overflow=0. i_roll_over is ignored while i_reset=1.
- o_valid defaults to 0 in every cycle that is not a measurement.
- IDLE, event: cnt<=1, go to MEASURE. No outputs change, because the first event only opens a period.
- IDLE, no event: hold.
- MEASURE, event (measurement):
  - o_k<=cnt and o_valid<=1.
  - o_locked<=(have_prev && cnt==o_k).
  - have_prev<=1, o_overflow<=0.
  - cnt<=1; stay in MEASURE.
- MEASURE, no event, cnt<2^N-1: cnt<=cnt+1.
- MEASURE, no event, cnt==2^N-1 (overflow):
  - o_overflow<=1, o_locked<=0, have_prev<=0.
  - cnt<=0, go to IDLE.
  - o_k is unchanged.
- Arithmetic: cnt never wraps. The overflow branch leaves MEASURE before cnt can wrap.
- Period semantics: events at cycles t and t+p give cnt==p at cycle t+p, so o_k=p.
- i_roll_over held continuously high is a period of 1. After the opening event, every cycle is a measurement with o_k=1.

## Timing
- All outputs are registered. A measurement on the event in cycle c is visible in cycle c+1.
- The first o_valid follows the second event seen after reset or overflow.
- o_locked first rises with the third event, i.e. with the second measurement.
- o_locked changes only in cycles where o_valid=1, with two exceptions: overflow and reset clear it.
- Simultaneous event and cnt==2^N-1: the event wins, so the cycle is a measurement with o_k=2^N-1 and no overflow.
- Overflow is registered one cycle after the last counting cycle, at event cycle t+2^N.
- Reset mid-measurement discards the partial count. The next event after reset only opens a period.

## Test plan
- Pulse every 3 cycles (N=8), events at cycles 5, 8, 11, 14 after reset:
  - cycle 9: o_valid=1, o_k=3, o_locked=0.
  - cycle 12: o_k=3, o_locked=1.
  - cycle 15: o_locked stays 1.
- i_roll_over held high from cycle t0:
  - t0+2: o_valid=1, o_k=1, o_locked=0.
  - from t0+3: o_valid=1 every cycle, o_locked=1.
- Period change 4,4,6,6:
  - o_locked=1 after the second 4.
  - first 6 measured: o_k=6, o_locked=0.
  - second 6 measured: o_locked=1.
- Range edge, event at t0:
  - next event at t0+255: o_k=255 at t0+256, o_overflow=0.
  - instead, no further event: o_overflow=1 and o_locked=0 at t0+256, FSM in IDLE.
  - after overflow, events at 10-cycle spacing: o_overflow clears at the second event's o_valid with o_k=10.
- Reset mid-period: lock with period 5, then assert i_reset for one cycle 2 cycles after an event.
  - All outputs read 0 the next cycle.
  - The next event produces no o_valid.
  - The following event 5 cycles later gives o_k=5, o_locked=0.
- i_roll_over pulsed while i_reset=1: no effect, and the FSM remains in IDLE after release.

Source files
------------

// File: rtl/rollover_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : rollover_period_meter
// Description : Recovers the modulus of a rollover pulse train by counting
//               the cycles between consecutive events. Reports each period,
//               flags lock on two equal consecutive periods and flags
//               overflow when no event arrives within 2^N-1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rollover_period_meter #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_roll_over,
    output logic [N-1:0] o_k,
    output logic         o_valid,
    output logic         o_locked,
    output logic         o_overflow
);

    localparam logic [0:0]   c_IDLE    = 1'b0;
    localparam logic [0:0]   c_MEASURE = 1'b1;
    localparam logic [N-1:0] c_CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] c_CNT_ONE = N'(1);

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_next;
    logic         r_have_prev;
    logic         w_have_prev_next;
    logic [N-1:0] r_k;
    logic [N-1:0] w_k_next;
    logic         r_valid;
    logic         w_valid_next;
    logic         r_locked;
    logic         w_locked_next;
    logic         r_overflow;
    logic         w_overflow_next;
    logic         w_at_max;

    assign w_at_max = (r_cnt == c_CNT_MAX);

    // State register: reset forces IDLE regardless of incoming events.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: first event opens a period; a full count without event
    // abandons the measurement so the counter never wraps.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_roll_over) begin
                    w_state_next = c_MEASURE;
                end
            end
            c_MEASURE: begin
                if (!i_roll_over && w_at_max) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output/datapath next values; an event at full count is still a
    // measurement, so the event check takes priority over overflow.
    always_comb begin
        w_cnt_next       = r_cnt;
        w_have_prev_next = r_have_prev;
        w_k_next         = r_k;
        w_valid_next     = 1'b0;
        w_locked_next    = r_locked;
        w_overflow_next  = r_overflow;
        case (r_state)
            c_IDLE: begin
                if (i_roll_over) begin
                    w_cnt_next = c_CNT_ONE;
                end
            end
            c_MEASURE: begin
                if (i_roll_over) begin
                    w_k_next         = r_cnt;
                    w_valid_next     = 1'b1;
                    w_locked_next    = r_have_prev && (r_cnt == r_k);
                    w_have_prev_next = 1'b1;
                    w_overflow_next  = 1'b0;
                    w_cnt_next       = c_CNT_ONE;
                end else if (w_at_max) begin
                    w_overflow_next  = 1'b1;
                    w_locked_next    = 1'b0;
                    w_have_prev_next = 1'b0;
                    w_cnt_next       = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_cnt_next = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_have_prev <= 1'b0;
            r_k         <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_have_prev <= w_have_prev_next;
            r_k         <= w_k_next;
            r_valid     <= w_valid_next;
            r_locked    <= w_locked_next;
            r_overflow  <= w_overflow_next;
        end
    end

    assign o_k        = r_k;
    assign o_valid    = r_valid;
    assign o_locked   = r_locked;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire
